inv_mixcolumn_seq: RTL and testbench

Column-serial AES InvMixColumns engine for the decryption datapath; it undoes the combinational forward MixColumns stage. It accepts one 128-bit state over a valid/ready handshake and processes one 32-bit column per clock. It holds the result in an output register until downstream accepts it. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round.

---
 rtl/aes_gf_pkg.sv | 57 +++++
 rtl/inv_mixcolumn_seq_if.sv | 27 ++
 rtl/inv_mixcol_column.sv | 32 +++
 rtl/inv_mixcolumn_seq.sv | 116 +++++++++++
 tb/tb_inv_mixcolumn_seq.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_gf_pkg.sv
// ============================================================================
// Module      : aes_gf_pkg
// Description : GF(2^8) helpers and FSM state type for the InvMixColumns engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_gf_pkg;

  localparam logic [7:0] c_gf_reduce = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } imc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? c_gf_reduce : 8'h00);
  endfunction

  // Higher multiples come from the x2/x4/x8 chain, so each multiply is three xtimes.
  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(x)));
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x8;
    x2 = xtime(x);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] x);
    logic [7:0] x4;
    logic [7:0] x8;
    x4 = xtime(xtime(x));
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inv_mixcolumn_seq_if.sv
// ============================================================================
// Module      : inv_mixcolumn_seq_if
// Description : Input/output valid-ready bus of the InvMixColumns engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inv_mixcolumn_seq_if;
  logic [127:0] in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/inv_mixcol_column.sv
// ============================================================================
// Module      : inv_mixcol_column
// Description : Combinational InvMixColumns of one 32-bit column (s0 in MSB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_mixcol_column
  import aes_gf_pkg::*;
(
  input  wire logic [31:0] i_col,
  output logic      [31:0] o_col
);

  logic [7:0] w_s0;
  logic [7:0] w_s1;
  logic [7:0] w_s2;
  logic [7:0] w_s3;

  assign w_s0 = i_col[31:24];
  assign w_s1 = i_col[23:16];
  assign w_s2 = i_col[15:8];
  assign w_s3 = i_col[7:0];

  assign o_col[31:24] = gf_mule(w_s0) ^ gf_mulb(w_s1) ^ gf_muld(w_s2) ^ gf_mul9(w_s3);
  assign o_col[23:16] = gf_mul9(w_s0) ^ gf_mule(w_s1) ^ gf_mulb(w_s2) ^ gf_muld(w_s3);
  assign o_col[15:8]  = gf_muld(w_s0) ^ gf_mul9(w_s1) ^ gf_mule(w_s2) ^ gf_mulb(w_s3);
  assign o_col[7:0]   = gf_mulb(w_s0) ^ gf_muld(w_s1) ^ gf_mul9(w_s2) ^ gf_mule(w_s3);

endmodule

`default_nettype wire

// File: rtl/inv_mixcolumn_seq.sv
// ============================================================================
// Module      : inv_mixcolumn_seq
// Description : Column-serial AES InvMixColumns engine with valid/ready I/O.
//               Define INV_MIXCOL_PARALLEL_EN to transform all columns at once.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_mixcolumn_seq
  import aes_gf_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  inv_mixcolumn_seq_if.slave bus
);

  imc_state_e   r_state;
  logic [127:0] r_work;
  logic [127:0] r_out;
  logic         r_out_valid;
  logic [127:0] w_work_next;
  logic         w_last;

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;

`ifdef INV_MIXCOL_PARALLEL_EN
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    inv_mixcol_column u_col (
      .i_col (r_work[gi*32 +: 32]),
      .o_col (w_work_next[gi*32 +: 32])
    );
  end

  assign w_last = 1'b1;
`else
  logic [1:0]  r_col_idx;
  logic [31:0] w_col_in;
  logic [31:0] w_col_out;

  // Column 0 sits in the top word, so col_idx counts down through the vector.
  always_comb begin
    w_col_in = r_work[127:96];
    case (r_col_idx)
      2'd0:    w_col_in = r_work[127:96];
      2'd1:    w_col_in = r_work[95:64];
      2'd2:    w_col_in = r_work[63:32];
      default: w_col_in = r_work[31:0];
    endcase
  end

  inv_mixcol_column u_col (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  always_comb begin
    w_work_next = r_work;
    case (r_col_idx)
      2'd0:    w_work_next[127:96] = w_col_out;
      2'd1:    w_work_next[95:64]  = w_col_out;
      2'd2:    w_work_next[63:32]  = w_col_out;
      default: w_work_next[31:0]   = w_col_out;
    endcase
  end

  assign w_last = (r_col_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_idx <= 2'd0;
    end else if (r_state == IDLE) begin
      r_col_idx <= 2'd0;
    end else if (r_state == CALC) begin
      r_col_idx <= r_col_idx + 2'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_work  <= bus.in;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_work <= w_work_next;
          if (w_last) begin
            r_out       <= w_work_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inv_mixcolumn_seq.sv
// ============================================================================
// Module      : tb_inv_mixcolumn_seq
// Description : Directed self-checking bench for inv_mixcolumn_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inv_mixcolumn_seq;

`ifdef INV_MIXCOL_PARALLEL_EN
  localparam int c_LAT    = 1;
  localparam int c_PERIOD = 3;
`else
  localparam int c_LAT    = 4;
  localparam int c_PERIOD = 6;
`endif

  localparam logic [127:0] c_FIPS_IN  = 128'h8e4da1bc9fdc589d01010101d5d5d7d6;
  localparam logic [127:0] c_FIPS_OUT = 128'hdb135345f20a225c01010101d4d4d4d5;
  localparam logic [127:0] c_C6       = 128'hc6c6c6c6c6c6c6c6c6c6c6c6c6c6c6c6;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  inv_mixcolumn_seq_if bus ();

  inv_mixcolumn_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fx2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] x);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = x[(3-c)*32 +: 32];
      r[(3-c)*32 +: 32] = {fx2(a0) ^ fx2(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ fx2(a1) ^ fx2(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ fx2(a2) ^ fx2(a3) ^ a3,
                           fx2(a0) ^ a0 ^ a1 ^ a2 ^ fx2(a3)};
    end
    return r;
  endfunction

  // Drives one state through the handshake; lat counts edges after capture.
  task automatic run_vec(input logic [127:0] d, output logic [127:0] res, output int lat);
    bus.in       = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    res           = bus.out;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.out !== 128'h0) begin n_err++; $display("FAIL reset_out: got %h expected %h", bus.out, 128'h0); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_in_rst: got %b expected 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_after: got %b expected 1", bus.in_ready); end
    // Reset and in_valid together: input must not be captured.
    rst          = 1'b1;
    bus.in       = c_FIPS_IN;
    bus.in_valid = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_wins_in_ready: got %b expected 1", bus.in_ready); end
    for (int i = 0; i < 6; i++) tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_wins_out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_fips();
    logic [127:0] res;
    int lat;
    run_vec(c_FIPS_IN, res, lat);
    n_vec++; if (res !== c_FIPS_OUT) begin n_err++; $display("FAIL fips_out: got %h expected %h", res, c_FIPS_OUT); end
    n_vec++; if (lat !== c_LAT) begin n_err++; $display("FAIL fips_latency: got %0d expected %0d", lat, c_LAT); end
  endtask

  task automatic test_fixed_points();
    logic [127:0] res;
    int lat;
    run_vec(c_C6, res, lat);
    n_vec++; if (res !== c_C6) begin n_err++; $display("FAIL fixed_c6: got %h expected %h", res, c_C6); end
    run_vec(128'h0, res, lat);
    n_vec++; if (res !== 128'h0) begin n_err++; $display("FAIL fixed_zero: got %h expected %h", res, 128'h0); end
  endtask

  task automatic test_round_trip();
    logic [127:0] x, res;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      run_vec(fwd_mix(x), res, lat);
      n_vec++;
      if (res !== x) begin n_err++; $display("FAIL round_trip[%0d]: got %h expected %h", i, res, x); end
    end
  endtask

  task automatic test_backpressure();
    int k;
    bus.in       = c_FIPS_IN;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 20) begin tick(); k++; end
    n_vec++; if (k !== c_LAT) begin n_err++; $display("FAIL bp_latency: got %0d expected %0d", k, c_LAT); end
    // Junk input while stalled must be ignored.
    bus.in       = 128'h00112233445566778899aabbccddeeff;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++; if (bus.out !== c_FIPS_OUT) begin n_err++; $display("FAIL bp_out_hold[%0d]: got %h expected %h", i, bus.out, c_FIPS_OUT); end
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold[%0d]: got %b expected 1", i, bus.out_valid); end
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
    n_vec++; if (bus.out !== c_FIPS_OUT) begin n_err++; $display("FAIL bp_out_kept: got %h expected %h", bus.out, c_FIPS_OUT); end
  endtask

  task automatic test_reset_mid_calc();
    logic [127:0] res;
    int lat;
    bus.in       = c_C6;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_vec++; if (bus.out !== 128'h0) begin n_err++; $display("FAIL midcalc_out: got %h expected %h", bus.out, 128'h0); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midcalc_valid: got %b expected 0", bus.out_valid); end
    rst = 1'b0;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midcalc_in_ready: got %b expected 1", bus.in_ready); end
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midcalc_no_partial: got %b expected 0", bus.out_valid); end
    run_vec(c_FIPS_IN, res, lat);
    n_vec++; if (res !== c_FIPS_OUT) begin n_err++; $display("FAIL midcalc_next_out: got %h expected %h", res, c_FIPS_OUT); end
    n_vec++; if (lat !== c_LAT) begin n_err++; $display("FAIL midcalc_next_latency: got %0d expected %0d", lat, c_LAT); end
  endtask

  task automatic test_busy_input();
    int cnt;
    bus.in       = c_FIPS_IN;
    bus.in_valid = 1'b1;
    tick();
    bus.in       = 128'h0123456789abcdef0123456789abcdef;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid === 1'b1) begin
        cnt++;
        n_vec++; if (bus.out !== c_FIPS_OUT) begin n_err++; $display("FAIL busy_out: got %h expected %h", bus.out, c_FIPS_OUT); end
      end
      tick();
    end
    bus.out_ready = 1'b0;
    n_vec++; if (cnt !== 1) begin n_err++; $display("FAIL busy_valid_count: got %0d expected 1", cnt); end
  endtask

  task automatic test_back_to_back();
    int last, accepts, k;
    last         = -1;
    accepts      = 0;
    bus.in       = c_FIPS_IN;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.in_ready === 1'b1) begin
        if (last >= 0) begin
          n_vec++; if (c - last !== c_PERIOD) begin n_err++; $display("FAIL b2b_period: got %0d expected %0d", c - last, c_PERIOD); end
        end
        last = c;
        accepts++;
      end
      if (bus.out_valid === 1'b1) begin
        n_vec++; if (bus.out !== c_FIPS_OUT) begin n_err++; $display("FAIL b2b_out: got %h expected %h", bus.out, c_FIPS_OUT); end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    n_vec++; if (accepts < 40 / c_PERIOD) begin n_err++; $display("FAIL b2b_accepts: got %0d expected >= %0d", accepts, 40 / c_PERIOD); end
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 20) begin tick(); k++; end
    bus.out_ready = 1'b0;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_drain: got %b expected 1", bus.in_ready); end
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in        = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fips();
    test_fixed_points();
    test_round_trip();
    test_backpressure();
    test_reset_mid_calc();
    test_busy_input();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
